// File: rtl/doppler_if_freq_meter_if.sv
// doppler_if_freq_meter_if: IF input, setpoint and measurement signals of the IF frequency meter
interface doppler_if_freq_meter_if #(
    parameter int IFCNT_W = 12
);
    logic               ifin;
    logic [IFCNT_W-1:0] dopset;
    logic               scan_tick;
    logic               track_tick;
    logic               ifedge;
    logic [IFCNT_W-1:0] ifcnt;
    logic [IFCNT_W-1:0] iffreq;
    logic               ifcomp;

    modport master (
        output ifin, dopset,
        input  scan_tick, track_tick, ifedge, ifcnt, iffreq, ifcomp
    );

    modport slave (
        input  ifin, dopset,
        output scan_tick, track_tick, ifedge, ifcnt, iffreq, ifcomp
    );
endinterface

// File: rtl/doppler_if_freq_meter.sv
// doppler_if_freq_meter: gated IF edge counter with scan/track timebase and Doppler setpoint comparator
module doppler_if_freq_meter #(
    parameter int SCAN_DIV  = 122760,
    parameter int TRACK_DIV = 8,
    parameter int IFCNT_W   = 12
) (
    input logic                    clk,
    input logic                    rst,
    doppler_if_freq_meter_if.slave bus
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int TW = (TRACK_DIV > 1) ? $clog2(TRACK_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] TRACK_LAST = TW'(TRACK_DIV - 1);

    logic [SW-1:0]      scan_cnt;
    logic [TW-1:0]      track_cnt;
    logic               s1, s2, s3;
    logic [IFCNT_W-1:0] ifcnt;
    logic [IFCNT_W-1:0] iffreq;
    logic               ifcomp;
    logic               scan_tick;
    logic               track_tick;
    logic               ifedge;

    assign scan_tick  = scan_cnt == SCAN_LAST;
    assign track_tick = scan_tick && track_cnt == TRACK_LAST;
    assign ifedge     = s2 && !s3;

    assign bus.scan_tick  = scan_tick;
    assign bus.track_tick = track_tick;
    assign bus.ifedge     = ifedge;
    assign bus.ifcnt      = ifcnt;
    assign bus.iffreq     = iffreq;
    assign bus.ifcomp     = ifcomp;

    // free-running scan-rate prescaler
    always_ff @(posedge clk) begin
        if (!rst)
            scan_cnt <= '0;
        else
            scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
    end

    // track-rate divider, advanced once per scan tick
    always_ff @(posedge clk) begin
        if (!rst)
            track_cnt <= '0;
        else if (scan_tick)
            track_cnt <= (track_cnt == TRACK_LAST) ? '0 : track_cnt + 1'b1;
    end

    // two-flop synchronizer for the async IF input plus a delay flop for rising-edge detection
    always_ff @(posedge clk) begin
        if (!rst)
            {s1, s2, s3} <= 3'b000;
        else
            {s1, s2, s3} <= {bus.ifin, s1, s2};
    end

    // window edge counter; an edge coincident with the gate opens the new window at 1
    always_ff @(posedge clk) begin
        if (!rst)
            ifcnt <= '0;
        else if (track_tick)
            ifcnt <= IFCNT_W'(ifedge);
        else if (ifedge)
            ifcnt <= ifcnt + 1'b1;
    end

    // latch the completed window count and compare it with the setpoint at each gate
    always_ff @(posedge clk) begin
        if (!rst) begin
            iffreq <= '0;
            ifcomp <= 1'b1;
        end else if (track_tick) begin
            iffreq <= ifcnt;
            ifcomp <= !(ifcnt > bus.dopset);
        end
    end
endmodule

// File: tb/tb_doppler_if_freq_meter.sv
// tb_doppler_if_freq_meter: randomized scoreboard bench for the gated IF frequency meter
module tb_doppler_if_freq_meter;
    localparam int SCAN_DIV  = 10;
    localparam int TRACK_DIV = 4;
    localparam int W         = 12;
    localparam int WW        = 4;
    localparam int GATE      = SCAN_DIV * TRACK_DIV;
    localparam int MOD       = 1 << W;

    typedef struct {
        int freq;
        int comp;
    } exp_t;

    logic clk = 0;
    logic rst = 0;
    int   errors = 0;
    int   checks = 0;
    int   mode = 0;
    int   ph = 0;
    int   cyc = 0;

    exp_t sb[$];
    bit   smp[$] = '{0, 0, 0};
    int   m_k = 0;
    int   m_cnt = 0;
    int   m_freq = 0;
    int   m_comp = 1;
    bit   m_rst = 1;
    bit   gate_pend = 0;

    doppler_if_freq_meter_if #(.IFCNT_W(W))  bus ();
    doppler_if_freq_meter_if #(.IFCNT_W(WW)) busw ();

    doppler_if_freq_meter #(.SCAN_DIV(SCAN_DIV), .TRACK_DIV(TRACK_DIV), .IFCNT_W(W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    doppler_if_freq_meter #(.SCAN_DIV(SCAN_DIV), .TRACK_DIV(TRACK_DIV), .IFCNT_W(WW)) dut_w (
        .clk(clk), .rst(rst), .bus(busw)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // IF waveform generator: 0 toggle, 1 period-4, 2 random, 3 driven by the stimulus block
    always @(negedge clk) begin
        ph++;
        busw.ifin = !busw.ifin;
        if (mode == 0)
            bus.ifin = !bus.ifin;
        else if (mode == 1)
            bus.ifin = ph[1];
        else if (mode == 2)
            bus.ifin = 1'($urandom_range(0, 1));
    end

    // reference model: cycle index since reset, sampled IF history, edges counted per gate window
    always @(posedge clk) begin
        bit e;
        m_rst = !rst;
        if (!rst) begin
            m_k = 0;
            m_cnt = 0;
            m_freq = 0;
            m_comp = 1;
            smp = '{0, 0, 0};
            sb.delete();
        end else begin
            e = smp[1] && !smp[2];
            if (m_k % GATE == GATE - 1) begin
                m_freq = m_cnt % MOD;
                m_comp = (m_freq > int'(bus.dopset)) ? 0 : 1;
                sb.push_back('{m_freq, m_comp});
                m_cnt = int'(e);
            end else
                m_cnt += int'(e);
            m_k++;
            smp.push_front(bus.ifin);
            void'(smp.pop_back());
        end
    end

    // monitor: pops the expected latch after each DUT gate and checks the live outputs every cycle
    always @(posedge clk) begin
        exp_t ex;
        #1;
        if (gate_pend && !m_rst) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL gate_unexpected: got gate expected none");
            end else begin
                ex = sb.pop_front();
                check("gate_iffreq", 32'(bus.iffreq), ex.freq);
                check("gate_ifcomp", 32'(bus.ifcomp), ex.comp);
            end
        end
        check("scan_tick", 32'(bus.scan_tick), 32'(m_k % SCAN_DIV == SCAN_DIV - 1));
        check("track_tick", 32'(bus.track_tick), 32'(m_k % GATE == GATE - 1));
        check("ifedge", 32'(bus.ifedge), 32'(smp[1] && !smp[2]));
        check("ifcnt", 32'(bus.ifcnt), m_cnt % MOD);
        check("iffreq", 32'(bus.iffreq), m_freq);
        check("ifcomp", 32'(bus.ifcomp), m_comp);
        gate_pend = bus.track_tick;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        cyc += n;
    endtask

    task automatic first_ticks(input string tag);
        int fs = -1;
        int ft = -1;
        for (int i = 1; i <= 100 && ft < 0; i++) begin
            step(1);
            if (bus.scan_tick && fs < 0) fs = i;
            if (bus.track_tick) ft = i;
        end
        check({tag, "_first_scan"}, fs, 9);
        check({tag, "_first_track"}, ft, GATE - 1);
    endtask

    initial begin
        bus.ifin = 0;
        bus.dopset = 12'd10;
        busw.ifin = 0;
        busw.dopset = 4'd3;
        rst = 0;
        mode = 0;
        repeat (5) @(negedge clk);
        check("rst_iffreq", 32'(bus.iffreq), 0);
        check("rst_ifcnt", 32'(bus.ifcnt), 0);
        check("rst_ifcomp", 32'(bus.ifcomp), 1);
        check("rst_scan_tick", 32'(bus.scan_tick), 0);
        check("rst_track_tick", 32'(bus.track_tick), 0);
        rst = 1;
        mode = 1;
        cyc = 0;
        first_ticks("start");
        step(125 - cyc);
        check("freq_p4", 32'(bus.iffreq), 10);
        check("comp_eq", 32'(bus.ifcomp), 1);
        check("wrap_iffreq", 32'(busw.iffreq), 4);
        check("wrap_ifcomp", 32'(busw.ifcomp), 0);
        bus.dopset = 12'd9;
        step(5);
        check("comp_hold", 32'(bus.ifcomp), 1);
        step(161 - cyc);
        check("comp_gt", 32'(bus.ifcomp), 0);
        check("freq_p4_b", 32'(bus.iffreq), 10);
        bus.dopset = 12'd10;
        step(201 - cyc);
        check("comp_eq_b", 32'(bus.ifcomp), 1);
        mode = 3;
        bus.ifin = 0;
        step(237 - cyc);
        bus.ifin = 1;
        step(2);
        check("coinc_edge", 32'(bus.ifedge), 1);
        check("coinc_gate", 32'(bus.track_tick), 1);
        step(1);
        check("coinc_ifcnt", 32'(bus.ifcnt), 1);
        mode = 2;
        for (int i = 0; i < 12; i++) begin
            bus.dopset = 12'($urandom_range(0, 30));
            step(int'($urandom_range(20, 50)));
        end
        rst = 0;
        step(2);
        rst = 1;
        cyc = 0;
        step(24);
        rst = 0;
        step(1);
        check("midrst_ifcnt", 32'(bus.ifcnt), 0);
        check("midrst_iffreq", 32'(bus.iffreq), 0);
        rst = 1;
        cyc = 0;
        first_ticks("midrst");
        for (int i = 0; i < 6; i++) begin
            bus.dopset = 12'($urandom_range(0, 30));
            step(int'($urandom_range(20, 50)));
        end
        step(3);
        check("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
